branch_target_buffer: RTL and testbench



---
 rtl/branch_target_buffer.sv | 130 +++++++++++++
 tb/tb_branch_target_buffer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational next-PC prediction for IF, mispredict check and redirect for ID.
// Optional macro BTB_COUNTER_EN enables 2-bit saturating direction counters; otherwise a hit always predicts taken.
module branch_target_buffer #(
   parameter int INDEX_BITS = 6
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] Instr_PC_IN_IF,
   input  logic [31:0] Instr_PC_IN_ID,
   input  logic        is_Branch_IN_ID,
   input  logic        is_Taken_IN_ID,
   input  logic [31:0] Alt_PC_IN_ID,
   output logic        FLUSH,
   output logic        take_Branch_OUT_IF,
   output logic [31:0] take_Alt_PC_OUT_IF
);

   localparam int ENTRIES  = 1 << INDEX_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS;

   logic                valid_reg  [ENTRIES];
   logic [TAG_BITS-1:0] tag_reg    [ENTRIES];
   logic [31:0]         target_reg [ENTRIES];
`ifdef BTB_COUNTER_EN
   logic [1:0]          ctr_reg    [ENTRIES];
   logic [1:0]          ctr_next;
`endif

   logic [INDEX_BITS-1:0] if_index, id_index;
   logic [TAG_BITS-1:0]   if_tag, id_tag;
   logic                  if_hit, id_hit;
   logic                  if_pred_taken, id_pred_taken;
   logic [31:0]           if_target, id_target;
   logic                  mispredict;
   logic [31:0]           redirect_pc;
   logic                  unused_pc_bits;

   assign if_index = Instr_PC_IN_IF[INDEX_BITS+1:2];
   assign id_index = Instr_PC_IN_ID[INDEX_BITS+1:2];
   assign if_tag   = Instr_PC_IN_IF[31:INDEX_BITS+2];
   assign id_tag   = Instr_PC_IN_ID[31:INDEX_BITS+2];
   assign unused_pc_bits = ^{Instr_PC_IN_IF[1:0], Instr_PC_IN_ID[1:0]};

   // Both ports read the table as it stands before this cycle's write.
   assign if_hit    = valid_reg[if_index] && (tag_reg[if_index] == if_tag);
   assign id_hit    = valid_reg[id_index] && (tag_reg[id_index] == id_tag);
   assign if_target = target_reg[if_index];
   assign id_target = target_reg[id_index];

`ifdef BTB_COUNTER_EN
   assign if_pred_taken = if_hit && ctr_reg[if_index][1];
   assign id_pred_taken = id_hit && ctr_reg[id_index][1];

   always_comb begin
      ctr_next = ctr_reg[id_index];
      if (is_Taken_IN_ID) begin
         if (ctr_reg[id_index] != 2'b11) ctr_next = ctr_reg[id_index] + 2'b01;
      end else begin
         if (ctr_reg[id_index] != 2'b00) ctr_next = ctr_reg[id_index] - 2'b01;
      end
   end
`else
   assign if_pred_taken = if_hit;
   assign id_pred_taken = id_hit;
`endif

   always_comb begin
      mispredict  = 1'b0;
      redirect_pc = Instr_PC_IN_ID + 32'd4;
      if (is_Branch_IN_ID) begin
         if (is_Taken_IN_ID) begin
            mispredict  = !id_pred_taken || (id_target != Alt_PC_IN_ID);
            redirect_pc = Alt_PC_IN_ID;
         end else begin
            mispredict  = id_pred_taken;
            // Skip the delay slot, which has already been fetched.
            redirect_pc = Instr_PC_IN_ID + 32'd8;
         end
      end else begin
         mispredict = id_pred_taken;
      end
   end

   always_comb begin
      FLUSH              = 1'b0;
      take_Branch_OUT_IF = 1'b0;
      take_Alt_PC_OUT_IF = 32'd0;
      if (RESET) begin
         FLUSH              = mispredict;
         take_Branch_OUT_IF = mispredict || if_pred_taken;
         if (mispredict)
            take_Alt_PC_OUT_IF = redirect_pc;
         else if (if_pred_taken)
            take_Alt_PC_OUT_IF = if_target;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_reg[i]  <= 1'b0;
            tag_reg[i]    <= '0;
            target_reg[i] <= '0;
`ifdef BTB_COUNTER_EN
            ctr_reg[i]    <= 2'b00;
`endif
         end
      end else if (is_Branch_IN_ID) begin
         if (id_hit) begin
            if (is_Taken_IN_ID) target_reg[id_index] <= Alt_PC_IN_ID;
`ifdef BTB_COUNTER_EN
            ctr_reg[id_index] <= ctr_next;
`else
            if (!is_Taken_IN_ID) valid_reg[id_index] <= 1'b0;
`endif
         end else if (is_Taken_IN_ID) begin
            valid_reg[id_index]  <= 1'b1;
            tag_reg[id_index]    <= id_tag;
            target_reg[id_index] <= Alt_PC_IN_ID;
`ifdef BTB_COUNTER_EN
            ctr_reg[id_index]    <= 2'b10;
`endif
         end
      end else if (id_hit) begin
         // A non-branch hitting the table is an alias; drop the entry.
         valid_reg[id_index] <= 1'b0;
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: per-cycle vector table plus hand-written reset sequences.
module tb_branch_target_buffer;

   logic        CLK;
   logic        RESET;
   logic [31:0] Instr_PC_IN_IF;
   logic [31:0] Instr_PC_IN_ID;
   logic        is_Branch_IN_ID;
   logic        is_Taken_IN_ID;
   logic [31:0] Alt_PC_IN_ID;
   logic        FLUSH;
   logic        take_Branch_OUT_IF;
   logic [31:0] take_Alt_PC_OUT_IF;

   int tests_run = 0;
   int tests_failed = 0;

   branch_target_buffer #(.INDEX_BITS(6)) dut (
      .CLK                (CLK),
      .RESET              (RESET),
      .Instr_PC_IN_IF     (Instr_PC_IN_IF),
      .Instr_PC_IN_ID     (Instr_PC_IN_ID),
      .is_Branch_IN_ID    (is_Branch_IN_ID),
      .is_Taken_IN_ID     (is_Taken_IN_ID),
      .Alt_PC_IN_ID       (Alt_PC_IN_ID),
      .FLUSH              (FLUSH),
      .take_Branch_OUT_IF (take_Branch_OUT_IF),
      .take_Alt_PC_OUT_IF (take_Alt_PC_OUT_IF)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic [31:0] if_pc;
      logic [31:0] id_pc;
      logic        br;
      logic        tk;
      logic [31:0] alt;
      logic        exp_flush;
      logic        exp_take;
      logic [31:0] exp_tgt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [31:0] if_pc, input logic [31:0] id_pc, input logic br,
                      input logic tk, input logic [31:0] alt, input logic fl,
                      input logic tb, input logic [31:0] tgt);
      vec_t v;
      v.if_pc = if_pc; v.id_pc = id_pc; v.br = br; v.tk = tk; v.alt = alt;
      v.exp_flush = fl; v.exp_take = tb; v.exp_tgt = tgt;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] if_pc, input logic [31:0] id_pc, input logic br,
                        input logic tk, input logic [31:0] alt);
      Instr_PC_IN_IF  = if_pc;
      Instr_PC_IN_ID  = id_pc;
      is_Branch_IN_ID = br;
      is_Taken_IN_ID  = tk;
      Alt_PC_IN_ID    = alt;
   endtask

   localparam logic [31:0] IDLE_ID = 32'h0000_0000;
   localparam logic [31:0] IFX     = 32'h0040_0000;

   initial begin
      // Vectors applied one per cycle; table state carries from row to row.
      add(IFX,          IDLE_ID,      0, 0, 0,            0, 0, 32'h0);
      add(IFX,          32'h00400010, 1, 1, 32'h00400100, 1, 1, 32'h00400100);
      add(32'h00400010, IDLE_ID,      0, 0, 0,            0, 1, 32'h00400100);
      add(32'h00400010, 32'h00400010, 1, 0, 0,            1, 1, 32'h00400018);
      add(32'h00400010, IDLE_ID,      0, 0, 0,            0, 0, 32'h0);
      add(IFX,          32'h00400010, 1, 0, 0,            0, 0, 32'h0);
      add(32'h00400010, IDLE_ID,      0, 0, 0,            0, 0, 32'h0);
      add(IFX,          32'h00400020, 1, 1, 32'h00400100, 1, 1, 32'h00400100);
      add(IFX,          32'h00400020, 1, 1, 32'h00400200, 1, 1, 32'h00400200);
      add(32'h00400020, IDLE_ID,      0, 0, 0,            0, 1, 32'h00400200);
      add(32'h00400020, 32'h00400020, 1, 1, 32'h00400200, 0, 1, 32'h00400200);
      add(IFX,          32'h00400020, 1, 0, 0,            1, 1, 32'h00400028);
`ifdef BTB_COUNTER_EN
      add(32'h00400020, IDLE_ID,      0, 0, 0,            0, 1, 32'h00400200);
`else
      add(32'h00400020, IDLE_ID,      0, 0, 0,            0, 0, 32'h0);
`endif
      add(IFX,          32'h00400410, 1, 1, 32'h00400500, 1, 1, 32'h00400500);
      add(32'h00400010, IDLE_ID,      0, 0, 0,            0, 0, 32'h0);
      add(32'h00400410, IDLE_ID,      0, 0, 0,            0, 1, 32'h00400500);
      add(IFX,          32'h00400410, 0, 0, 0,            1, 1, 32'h00400414);
      add(32'h00400410, IDLE_ID,      0, 0, 0,            0, 0, 32'h0);
      add(IFX,          32'hFFFFFFF8, 1, 1, 32'h00400300, 1, 1, 32'h00400300);
      add(IFX,          32'hFFFFFFF8, 1, 0, 0,            1, 1, 32'h00000000);
      add(32'h00400030, 32'h00400030, 1, 1, 32'h00400600, 1, 1, 32'h00400600);

      RESET = 1'b1;
      drive(IFX, 32'h00400010, 1, 1, 32'h00400100);
      #1 RESET = 1'b0;
      #1;
      check("reset_flush", {31'd0, FLUSH}, 32'd0);
      check("reset_take", {31'd0, take_Branch_OUT_IF}, 32'd0);
      check("reset_target", take_Alt_PC_OUT_IF, 32'd0);
      $display("[TB] reset held with live ID branch: flush=%0b take=%0b tgt=%h",
               FLUSH, take_Branch_OUT_IF, take_Alt_PC_OUT_IF);
      @(posedge CLK);
      @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         if (i != 0) @(negedge CLK);
         drive(vecs[i].if_pc, vecs[i].id_pc, vecs[i].br, vecs[i].tk, vecs[i].alt);
         #2;
         $display("[TB] vec %0d if=%h id=%h br=%0b tk=%0b alt=%h -> flush=%0b take=%0b tgt=%h",
                  i, vecs[i].if_pc, vecs[i].id_pc, vecs[i].br, vecs[i].tk, vecs[i].alt,
                  FLUSH, take_Branch_OUT_IF, take_Alt_PC_OUT_IF);
         check($sformatf("vec%0d_flush", i), {31'd0, FLUSH}, {31'd0, vecs[i].exp_flush});
         check($sformatf("vec%0d_take", i), {31'd0, take_Branch_OUT_IF}, {31'd0, vecs[i].exp_take});
         check($sformatf("vec%0d_target", i), take_Alt_PC_OUT_IF, vecs[i].exp_tgt);
      end

      // Live entry at 0x00400030, then reset in the middle of a cycle.
      @(negedge CLK);
      drive(32'h00400030, IDLE_ID, 0, 0, 0);
      #2;
      check("live_take", {31'd0, take_Branch_OUT_IF}, 32'd1);
      check("live_target", take_Alt_PC_OUT_IF, 32'h00400600);
      $display("[TB] live entry before reset: take=%0b tgt=%h", take_Branch_OUT_IF, take_Alt_PC_OUT_IF);
      drive(32'h00400030, 32'h00400040, 1, 1, 32'h00400700);
      #1 RESET = 1'b0;
      #1;
      check("midreset_flush", {31'd0, FLUSH}, 32'd0);
      check("midreset_take", {31'd0, take_Branch_OUT_IF}, 32'd0);
      check("midreset_target", take_Alt_PC_OUT_IF, 32'd0);
      $display("[TB] mid-run reset: flush=%0b take=%0b tgt=%h", FLUSH, take_Branch_OUT_IF, take_Alt_PC_OUT_IF);
      @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      drive(32'h00400030, IDLE_ID, 0, 0, 0);
      #2;
      check("post_reset_take", {31'd0, take_Branch_OUT_IF}, 32'd0);
      check("post_reset_target", take_Alt_PC_OUT_IF, 32'd0);
      $display("[TB] after reset lookup of old PC: take=%0b tgt=%h", take_Branch_OUT_IF, take_Alt_PC_OUT_IF);
      drive(32'h00400040, IDLE_ID, 0, 0, 0);
      #1;
      check("post_reset_pending", {31'd0, take_Branch_OUT_IF}, 32'd0);
      $display("[TB] lookup of branch presented during reset: take=%0b", take_Branch_OUT_IF);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
